seq_detect_prog: RTL

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_prog.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Purpose  : Programmable serial pattern detector. A PAT_W-bit pattern is
//            shifted in serially while load=1; once a full pattern is held,
//            the incoming stream is compared bit by bit and each complete
//            match produces a one-cycle registered pulse and bumps a
//            saturating match counter. Overlapping or non-overlapping
//            matching is selected per cycle by the overlap input.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            load      - 1 = shift din into the pattern register
//            din       - serial pattern / stream bit
//            overlap   - 1 = overlapping matches, 0 = non-overlapping
//            dout      - one-cycle match pulse (registered)
//            armed     - full pattern loaded and detection active
//            match_cnt - saturating count of matches since last load start
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             din,
  input  logic             overlap,
  output logic             dout,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int LCW = $clog2(PAT_W + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_DETECT = 2'd2;

  localparam logic [LCW-1:0]   C_FULL    = LCW'(PAT_W);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LCW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [LCW-1:0]   hist_cnt_q, hist_cnt_d;
  logic             dout_q, dout_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic [PAT_W-1:0] w_hist_shift;
  logic [LCW-1:0]   w_hist_cnt_inc;
  logic             w_match;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      hist_q      <= '0;
      ld_cnt_q    <= '0;
      hist_cnt_q  <= '0;
      dout_q      <= 1'b0;
      armed_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      hist_q      <= hist_d;
      ld_cnt_q    <= ld_cnt_d;
      hist_cnt_q  <= hist_cnt_d;
      dout_q      <= dout_d;
      armed_q     <= armed_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:   state_d = (ld_cnt_q == C_FULL) ? ST_DETECT : ST_IDLE;
        ST_IDLE:   state_d = ST_IDLE;
        ST_DETECT: state_d = ST_DETECT;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Match is judged on the history as it will look after this edge, so the
  // pulse lands on the same edge that samples the final matching bit.
  assign w_hist_shift   = {hist_q[PAT_W-2:0], din};
  assign w_hist_cnt_inc = (hist_cnt_q == C_FULL) ? hist_cnt_q : hist_cnt_q + LCW'(1);
  assign w_match        = (state_q == ST_DETECT) && !load &&
                          (w_hist_shift == pat_q) && (w_hist_cnt_inc == C_FULL);

  // --------------------------------------------------------------------------
  // Output and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    pat_d       = pat_q;
    hist_d      = hist_q;
    ld_cnt_d    = ld_cnt_q;
    hist_cnt_d  = hist_cnt_q;
    match_cnt_d = match_cnt_q;
    dout_d      = 1'b0;
    armed_d     = (state_d == ST_DETECT);

    if (load) begin
      // Loading always abandons any partial stream history.
      hist_d     = '0;
      hist_cnt_d = '0;
      if (state_q != ST_LOAD) begin
        pat_d       = {{(PAT_W-1){1'b0}}, din};
        ld_cnt_d    = LCW'(1);
        match_cnt_d = '0;
      end else begin
        pat_d = {pat_q[PAT_W-2:0], din};
        if (ld_cnt_q != C_FULL) begin
          ld_cnt_d = ld_cnt_q + LCW'(1);
        end
      end
    end else if (state_q == ST_DETECT) begin
      hist_d     = w_hist_shift;
      hist_cnt_d = w_hist_cnt_inc;
      if (w_match) begin
        dout_d = 1'b1;
        if (match_cnt_q != C_CNT_MAX) begin
          match_cnt_d = match_cnt_q + CNT_W'(1);
        end
        // Non-overlapping: demand PAT_W fresh bits before the next match.
        if (!overlap) begin
          hist_cnt_d = '0;
        end
      end
    end
  end

  assign dout      = dout_q;
  assign armed     = armed_q;
  assign match_cnt = match_cnt_q;

endmodule
`default_nettype wire
